// File: rtl/priority_arbiter_8.sv
`timescale 1ns/1ps
// priority_arbiter_8
//   Shares one resource among eight requesters. Fixed priority (highest index
//   wins) or round-robin (search downward from the last granted index).
//   A grant is held until the owner drops its request, enable falls, or the
//   hold limit expires, at which point the grant moves on.
//
// Parameters
//   MAX_HOLD  max consecutive cycles a grant is held before forced
//             re-arbitration; 0 disables the limit
//   CNT_W     hold-counter width, 2**CNT_W > MAX_HOLD
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   enable     arbitration enable; low forces all grants off
//   rr_mode    0 = fixed priority, 1 = round-robin
//   req[7:0]   level requests, held until served
//   gnt[7:0]   registered one-hot grant, zero when idle
//   gnt_id     encoded index of the owner, 0 when idle
//   gnt_valid  high while a grant is active
//   timeout    one-cycle pulse when the hold limit is reached
module priority_arbiter_8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       rr_mode,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Counter value on the last permitted hold cycle. Only used when a
    // limit is configured, so the wrap for MAX_HOLD = 0 is harmless.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           r_state;
    logic [2:0]       r_gnt_id;
    logic [7:0]       r_gnt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [2:0]       r_last_id;
    logic             r_timeout;

    state_t           w_next_state;
    logic [2:0]       w_next_id;
    logic [7:0]       w_next_gnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic [2:0]       w_next_last;
    logic             w_next_tmo;

    logic [7:0]       w_owner_mask;
    logic [3:0]       w_pick_all;
    logic [3:0]       w_pick_oth;

    // Returns {found, index}. Fixed mode: highest set bit. Round-robin:
    // first set bit searching down from last-1 with wrap, so 'last' itself
    // is checked at the very end and has the lowest priority.
    function automatic logic [3:0] pick(input logic [7:0] mask,
                                        input logic       rr,
                                        input logic [2:0] last);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        if (!rr) begin
            for (int i = 0; i < 8; i++) begin
                if (mask[i]) res = {1'b1, 3'(i)};
            end
        end else begin
            // Walk from the farthest offset to the nearest so the nearest
            // set bit is the final assignment.
            for (int k = 8; k >= 1; k--) begin
                idx = 3'(int'(last) + 8 - k);
                if (mask[idx]) res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign w_owner_mask = 8'(1) << r_gnt_id;
    assign w_pick_all   = pick(req, rr_mode, r_last_id);
    assign w_pick_oth   = pick(req & ~w_owner_mask, rr_mode, r_last_id);

    always_comb begin
        w_next_state = r_state;
        w_next_id    = r_gnt_id;
        w_next_cnt   = r_hold_cnt;
        w_next_last  = r_last_id;
        w_next_tmo   = 1'b0;
        w_next_gnt   = 8'h00;

        case (r_state)
            IDLE: begin
                if (enable && (req != 8'h00)) begin
                    w_next_state = GRANT;
                    w_next_id    = w_pick_all[2:0];
                    w_next_last  = w_pick_all[2:0];
                    w_next_cnt   = '0;
                end
            end
            GRANT: begin
                if (!enable) begin
                    w_next_state = IDLE;
                    w_next_id    = 3'd0;
                    w_next_cnt   = '0;
                end else if (!req[r_gnt_id]) begin
                    // Owner released: hand straight over, no idle cycle.
                    w_next_cnt = '0;
                    if (w_pick_all[3]) begin
                        w_next_id   = w_pick_all[2:0];
                        w_next_last = w_pick_all[2:0];
                    end else begin
                        w_next_state = IDLE;
                        w_next_id    = 3'd0;
                    end
                end else if ((MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST)) begin
                    // Hold limit: pulse timeout, move on if anyone else waits,
                    // otherwise restart the hold window for the lone owner.
                    w_next_tmo = 1'b1;
                    w_next_cnt = '0;
                    if (w_pick_oth[3]) begin
                        w_next_id   = w_pick_oth[2:0];
                        w_next_last = w_pick_oth[2:0];
                    end
                end else if (r_hold_cnt != '1) begin
                    w_next_cnt = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_id    = 3'd0;
                w_next_cnt   = '0;
            end
        endcase

        if (w_next_state == GRANT) begin
            w_next_gnt = 8'(1) << w_next_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_gnt_id   <= 3'd0;
            r_gnt      <= 8'h00;
            r_hold_cnt <= '0;
            r_last_id  <= 3'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_gnt_id   <= w_next_id;
            r_gnt      <= w_next_gnt;
            r_hold_cnt <= w_next_cnt;
            r_last_id  <= w_next_last;
            r_timeout  <= w_next_tmo;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = (r_state == GRANT);
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_priority_arbiter_8.sv
`timescale 1ns/1ps
// Testbench for priority_arbiter_8 (MAX_HOLD = 4). The driver applies one
// vector per cycle and queues the hand-computed output expected after the
// next rising edge; an independent monitor pops and compares.
module tb_priority_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       rr_mode;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    logic [8:0] q_exp[$];   // {timeout, gnt}
    string      q_nm[$];
    event       mid_ev;

    priority_arbiter_8 #(
        .MAX_HOLD (4),
        .CNT_W    (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .rr_mode   (rr_mode),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compares one queued expectation per rising edge (sampled 1ns
    // later), or immediately after an asynchronous event.
    initial begin
        logic [8:0] e;
        string      nm;
        logic [2:0] eid;
        logic       evld;
        forever begin
            @(posedge clk or mid_ev);
            #1;
            if (q_exp.size() > 0) begin
                e  = q_exp.pop_front();
                nm = q_nm.pop_front();
                eid = 3'd0;
                for (int i = 0; i < 8; i++) if (e[i]) eid = 3'(i);
                evld = (e[7:0] != 8'h00);
                checks++;
                if (gnt !== e[7:0] || gnt_id !== eid || gnt_valid !== evld || timeout !== e[8]) begin
                    errors++;
                    $display("FAIL %s t=%0t: got gnt=%h id=%0d vld=%b tmo=%b, expected gnt=%h id=%0d vld=%b tmo=%b",
                             nm, $time, gnt, gnt_id, gnt_valid, timeout, e[7:0], eid, evld, e[8]);
                end
            end
        end
    end

    task automatic step(input logic rn, input logic [7:0] r, input logic en,
                        input logic rr, input logic [7:0] eg, input logic et,
                        input string nm);
        @(negedge clk);
        rst_n   = rn;
        req     = r;
        enable  = en;
        rr_mode = rr;
        q_exp.push_back({et, eg});
        q_nm.push_back(nm);
    endtask

    // Assert reset between edges; outputs must clear without a clock edge.
    task automatic async_rst();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        q_exp.push_back(9'h000);
        q_nm.push_back("async_rst");
        -> mid_ev;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        req     = 8'hFF;
        enable  = 1'b1;
        rr_mode = 1'b0;

        // Reset held with all requests asserted, then first grant to 7.
        for (int i = 0; i < 3; i++) step(1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, "rst_low");
        step(1'b1, 8'hFF, 1'b1, 1'b0, 8'h80, 1'b0, "rst_first");
        step(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "rel_idle");

        // Fixed priority with handover on release.
        step(1'b1, 8'h24, 1'b1, 1'b0, 8'h20, 1'b0, "fix5");
        step(1'b1, 8'h24, 1'b1, 1'b0, 8'h20, 1'b0, "fix5_hold");
        step(1'b1, 8'h04, 1'b1, 1'b0, 8'h04, 1'b0, "fix_drop5");
        step(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "fix_drop2");

        // Lone requester: timeout after hold cycles 4 and 8, grant kept.
        for (int c = 1; c <= 10; c++)
            step(1'b1, 8'h08, 1'b1, 1'b0, 8'h08, (c == 5 || c == 9), "lone");
        step(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "lone_rel");

        // Enable dropped mid-grant of requester 6, then re-raised.
        step(1'b1, 8'h40, 1'b1, 1'b0, 8'h40, 1'b0, "en_g6");
        step(1'b1, 8'h40, 1'b1, 1'b0, 8'h40, 1'b0, "en_g6_hold");
        step(1'b1, 8'h40, 1'b0, 1'b0, 8'h00, 1'b0, "en_off");
        step(1'b1, 8'h41, 1'b1, 1'b0, 8'h40, 1'b0, "en_fix_41");
        step(1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, "en_off2");
        step(1'b1, 8'h41, 1'b1, 1'b1, 8'h01, 1'b0, "en_rr_41");
        step(1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, "en_rel");

        // Asynchronous reset mid-grant (RR picks 1 after last grant 0).
        step(1'b1, 8'h02, 1'b1, 1'b1, 8'h02, 1'b0, "pre_rst_g1");
        step(1'b1, 8'h02, 1'b1, 1'b1, 8'h02, 1'b0, "pre_rst_hold");
        async_rst();
        step(1'b0, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, "rst_low2");

        // Round-robin rotation 7..0,7 with four cycles per owner.
        for (int o = 0; o < 9; o++) begin
            for (int c = 0; c < 4; c++) begin
                step(1'b1, 8'hFF, 1'b1, 1'b1, 8'(1) << (7 - (o % 8)),
                     (o > 0 && c == 0), "rr_rot");
            end
        end
        step(1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, "rr_rel");

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q_exp.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/priority_arbiter_8.md
# priority_arbiter_8

Sequential 8-requester arbiter built around highest-index-wins priority encoding. It shares one resource among eight requesters. Fixed-priority and round-robin modes are both supported, and grants are held until the requester releases or a hold limit expires. The block sits between requester agents and a shared datapath, and drives a registered one-hot grant and an encoded grant ID.

## Interface
- MAX_HOLD, 16: maximum consecutive cycles one requester may hold the grant while another request is pending; 0 means no limit.
- CNT_W, 5: hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  arbitration enable; low forces all grants off.
- rr_mode  input  1  0 = fixed priority, 1 = round-robin.
- req  input  8  request per requester; level, held until served.
- gnt  output  8  registered one-hot grant; all zeros when idle.
- gnt_id  output  3  encoded index of the granted requester; 0 when gnt_valid is 0.
- gnt_valid  output  1  high while any gnt bit is high.
- timeout  output  1  one-cycle pulse when the hold limit is reached.

## Operation
- States:
  - IDLE: gnt=0.
  - GRANT: exactly one gnt bit high.
- Winner selection (combinational, over the candidate mask):
  - Fixed mode: highest set index wins.
  - RR mode: search downward from index last_id-1, wrapping from 0 to 7. The last granted index therefore has lowest priority.
  - last_id resets to 0, so the first RR arbitration after reset matches fixed order (7 first).
- Transitions from IDLE:
  - enable=1 and req!=0 → GRANT to the winner; last_id is updated; hold_cnt is cleared.
  - Otherwise stay in IDLE.
- In GRANT, current owner i, evaluated at each edge in this order:
  1. enable=0: → IDLE; gnt cleared; hold_cnt cleared; last_id retained.
  2. req[i]=0: re-arbitrate over req. If any request is present, grant the new winner at the same edge, with no idle cycle. Otherwise → IDLE.
  3. MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1:
     - If req has another bit set: timeout pulses, and the grant moves to the winner over req with bit i masked.
     - If req has no other bit set: timeout pulses, grant stays on i, hold_cnt clears.
  4. Otherwise: hold the grant and increment hold_cnt (saturating).
- A change to rr_mode takes effect at the next arbitration. It never revokes a current grant.
- Requests arriving during a grant wait. Only the owner's req level matters while it holds the grant.
- gnt, gnt_id and gnt_valid are always mutually consistent, because all three are updated from one registered state.

## Timing
- Asynchronous reset (rst_n low) immediately forces:
  - gnt=8'h00, gnt_id=0, gnt_valid=0, timeout=0.
  - state=IDLE, hold_cnt=0, last_id=0.
- Reset release: the first arbitration happens at the first rising edge with rst_n high.
- Latency: req sampled at edge k → gnt high from edge k. This is 1 cycle from the sampling edge, with no combinational path from req to gnt.
- Release: owner drops req before edge k → gnt[i] low from edge k. The next grant, if any, is high from the same edge k.
- Hold limit: a grant made at edge k lasts at most MAX_HOLD cycles. Forced re-arbitration happens at edge k+MAX_HOLD.
- timeout is high for exactly the cycle following that edge.
- enable falling before edge k → gnt=0 from edge k. enable rising with a request pending → grant at the next edge.
- Reset asserted mid-grant: outputs clear asynchronously, without waiting for a clock edge.

## Test plan
- Reset with req=8'hFF held:
  - Outputs stay all zero while rst_n is low.
  - First edge after release → gnt=8'h80, gnt_id=7, gnt_valid=1.
- Fixed mode, req=8'b0010_0100:
  - gnt_id=5.
  - Drop req[5] → next edge gnt_id=2, with no idle cycle.
  - Drop req[2] → gnt=0.
- RR mode, MAX_HOLD=4, req=8'hFF held:
  - Grants rotate 7,6,5,4,3,2,1,0,7, four cycles each.
  - timeout pulses at every handover.
- Lone requester, MAX_HOLD=4, req=8'h08 held 10 cycles:
  - gnt=8'h08 throughout.
  - timeout pulses after cycles 4 and 8.
- enable dropped mid-grant of requester 6:
  - gnt=0 next edge.
  - Re-raise enable with req=8'h41 → gnt_id=6 in fixed mode, or gnt_id=0 in RR mode.
- rst_n asserted asynchronously between edges during a grant:
  - gnt, gnt_valid and timeout go to 0 before the next edge.
  - After release, RR order restarts from index 7.
